// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles a 32-bit little-endian word from four
// single-byte memory reads and holds it for IF/ID until it is consumed or redirected.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] inst_buf;
    logic [2:0]  issue_cnt;
    logic [2:0]  cap_cnt;
    logic        pend_p1;
    logic        capture;
    logic        accept;
    logic        last_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirect overrides everything: no request is raised and a returning byte is dropped.
    always_comb begin
        state_nxt  = state;
        mem_req_o  = 1'b0;
        mem_addr_o = pc + {29'd0, issue_cnt};
        capture    = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                mem_req_o = (issue_cnt < 3'd4) && !jump_flag_i;
                capture   = pend_p1 && !jump_flag_i;
                if (capture && (cap_cnt == 3'd3)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (jump_flag_i) begin
            state_nxt = FETCH;
        end
    end

    assign accept    = mem_req_o && mem_grant_i;
    assign last_byte = capture && (cap_cnt == 3'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            issue_cnt  <= 3'd0;
            cap_cnt    <= 3'd0;
            pend_p1    <= 1'b0;
            if_valid_o <= 1'b0;
            if_pc_o    <= 32'd0;
            if_inst_o  <= 32'd0;
        end else if (jump_flag_i) begin
            pc         <= {jump_addr_i[31:2], 2'b00};
            issue_cnt  <= 3'd0;
            cap_cnt    <= 3'd0;
            pend_p1    <= 1'b0;
            if_valid_o <= 1'b0;
        end else begin
            pend_p1 <= accept;
            if (accept) begin
                issue_cnt <= issue_cnt + 3'd1;
            end
            if (capture) begin
                inst_buf[{cap_cnt[1:0], 3'b000} +: 8] <= mem_rdata_i;
                cap_cnt <= cap_cnt + 3'd1;
            end
            if (last_byte) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc;
                if_inst_o  <= {mem_rdata_i, inst_buf[23:0]};
            end
            // Counters idle at zero outside FETCH so every FETCH entry starts clean.
            if (state != FETCH) begin
                issue_cnt <= 3'd0;
                cap_cnt   <= 3'd0;
            end
            if ((state == HOLD) && !stall_i) begin
                pc         <= pc + 32'd4;
                if_valid_o <= 1'b0;
            end
        end
    end

endmodule
